// File: rtl/golomb_result_store.sv
// Result store for the Golomb ruler search: keeps every ruler that shares the shortest
// length seen so far, then streams the stored rulers to the host one mark per beat.
module golomb_result_store #(
  parameter int WIDTH        = 9,
  parameter int NUMPOSITIONS = 5,
  parameter int NUMRESULTS   = 10,
  parameter int CNTW         = 6
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        clear,
  input  logic                                        cand_valid,
  output logic                                        cand_ready,
  input  logic [(NUMPOSITIONS+1)*WIDTH-1:0]           cand_marks,
  input  logic                                        search_done,
  output logic                                        done,
  output logic [WIDTH-1:0]                            best_length,
  output logic [CNTW-1:0]                             num_results,
  output logic                                        overflow,
  output logic [NUMRESULTS*(NUMPOSITIONS+1)*WIDTH-1:0] results,
  input  logic                                        rd_start,
  output logic                                        rd_valid,
  input  logic                                        rd_ready,
  output logic [WIDTH-1:0]                            rd_data,
  output logic                                        rd_last
);

  localparam int RW    = (NUMPOSITIONS + 1) * WIDTH;
  localparam int MARKW = (NUMPOSITIONS < 1) ? 1 : $clog2(NUMPOSITIONS + 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DONE    = 2'd1,
    ST_READ    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [RW-1:0]    r_slots [NUMRESULTS];
  logic [CNTW-1:0]  r_count;
  logic [WIDTH-1:0] r_best;
  logic             r_overflow;
  logic [CNTW-1:0]  r_rdSlot;
  logic [MARKW-1:0] r_rdMark;

  logic [WIDTH-1:0] w_candLen;
  logic             w_restart;
  logic             w_accept;
  logic             w_full;
  logic             w_lastWord;
  logic             w_handshake;
  logic             w_rdEnter;

  // Ruler length wraps modulo 2^WIDTH; mN sits in the LSBs, m0 in the MSBs.
  assign w_restart   = !reset || clear;
  assign w_candLen   = cand_marks[WIDTH-1:0] - cand_marks[RW-1 -: WIDTH];
  assign w_accept    = cand_valid && cand_ready;
  assign w_full      = (r_count == CNTW'(NUMRESULTS));
  assign w_lastWord  = (r_rdSlot == r_count - CNTW'(1)) && (r_rdMark == MARKW'(NUMPOSITIONS));
  assign w_handshake = rd_valid && rd_ready;
  assign w_rdEnter   = (r_state == ST_DONE) && rd_start && (r_count != '0);

  always_ff @(posedge clock) begin
    if (w_restart) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    cand_ready  = 1'b0;
    done        = 1'b0;
    rd_valid    = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        cand_ready = 1'b1;
        if (search_done) w_nextState = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (w_rdEnter) w_nextState = ST_READ;
      end
      ST_READ: begin
        done     = 1'b1;
        rd_valid = 1'b1;
        if (rd_ready && w_lastWord) w_nextState = ST_DONE;
      end
      default: w_nextState = ST_COLLECT;
    endcase
  end

  // A strictly shorter ruler restarts the collection; equal lengths append until full.
  always_ff @(posedge clock) begin
    if (w_restart) begin
      for (int i = 0; i < NUMRESULTS; i++) r_slots[i] <= '0;
      r_count    <= '0;
      r_best     <= '1;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      if (w_candLen < r_best) begin
        for (int i = 0; i < NUMRESULTS; i++) r_slots[i] <= (i == 0) ? cand_marks : '0;
        r_count    <= CNTW'(1);
        r_best     <= w_candLen;
        r_overflow <= 1'b0;
      end else if (w_candLen == r_best) begin
        if (w_full) begin
          r_overflow <= 1'b1;
        end else begin
          for (int i = 0; i < NUMRESULTS; i++) begin
            if (r_count == CNTW'(i)) r_slots[i] <= cand_marks;
          end
          r_count <= r_count + CNTW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_restart || w_rdEnter) begin
      r_rdSlot <= '0;
      r_rdMark <= '0;
    end else if (w_handshake) begin
      if (r_rdMark == MARKW'(NUMPOSITIONS)) begin
        r_rdMark <= '0;
        r_rdSlot <= r_rdSlot + CNTW'(1);
      end else begin
        r_rdMark <= r_rdMark + MARKW'(1);
      end
    end
  end

  assign best_length = r_best;
  assign num_results = r_count;
  assign overflow    = r_overflow;
  assign rd_last     = rd_valid && w_lastWord;

  // Slots beyond the valid count are masked so stale contents can never leak out.
  always_comb begin
    results = '0;
    for (int i = 0; i < NUMRESULTS; i++) begin
      if (CNTW'(i) < r_count) results[(NUMRESULTS-1-i)*RW +: RW] = r_slots[i];
    end
  end

  always_comb begin
    rd_data = '0;
    if (r_state == ST_READ) begin
      for (int i = 0; i < NUMRESULTS; i++) begin
        for (int k = 0; k <= NUMPOSITIONS; k++) begin
          if ((r_rdSlot == CNTW'(i)) && (r_rdMark == MARKW'(k))) begin
            rd_data = r_slots[i][(NUMPOSITIONS-k)*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_golomb_result_store.sv
// Bench for golomb_result_store: queue-based reference model compared every cycle,
// directed test-plan scenarios with literal expectations, then randomized rounds.
module tb_golomb_result_store;

  localparam int WIDTH = 9;
  localparam int NP    = 5;
  localparam int NR    = 10;
  localparam int CNTW  = 6;
  localparam int NW    = NP + 1;
  localparam int RW    = NW * WIDTH;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic               reset, clear, cand_valid, cand_ready, search_done, done, overflow;
  logic [RW-1:0]      cand_marks;
  logic [WIDTH-1:0]   best_length, rd_data;
  logic [CNTW-1:0]    num_results;
  logic [NR*RW-1:0]   results;
  logic               rd_start, rd_valid, rd_ready, rd_last;

  logic               sReset, sValid, sReady, sDone, sOvf, sRdValid, sRdLast;
  logic [RW-1:0]      sMarks;
  logic [WIDTH-1:0]   sBest, sRdData;
  logic [CNTW-1:0]    sNum;
  logic [2*RW-1:0]    sResults;
  logic               sClear = 1'b0, sSearchDone = 1'b0, sRdStart = 1'b0, sRdReady = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  bit checkEn     = 1'b0;

  golomb_result_store #(.WIDTH(WIDTH), .NUMPOSITIONS(NP), .NUMRESULTS(NR), .CNTW(CNTW)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_marks(cand_marks),
    .search_done(search_done), .done(done), .best_length(best_length),
    .num_results(num_results), .overflow(overflow), .results(results),
    .rd_start(rd_start), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last)
  );

  golomb_result_store #(.WIDTH(WIDTH), .NUMPOSITIONS(NP), .NUMRESULTS(2), .CNTW(CNTW)) dutSmall (
    .clock(clock), .reset(sReset), .clear(sClear),
    .cand_valid(sValid), .cand_ready(sReady), .cand_marks(sMarks),
    .search_done(sSearchDone), .done(sDone), .best_length(sBest),
    .num_results(sNum), .overflow(sOvf), .results(sResults),
    .rd_start(sRdStart), .rd_valid(sRdValid), .rd_ready(sRdReady),
    .rd_data(sRdData), .rd_last(sRdLast)
  );

  // Reference model: stored rulers as a queue, phase 0/1/2 = collecting/done/reading.
  logic [RW-1:0]    mSlots [$];
  logic [WIDTH-1:0] mBest;
  bit               mOvf;
  int               mPhase;
  int               mWord;

  function automatic logic [RW-1:0] mkRuler(int a, int b, int c, int d, int e, int f);
    return {WIDTH'(a), WIDTH'(b), WIDTH'(c), WIDTH'(d), WIDTH'(e), WIDTH'(f)};
  endfunction

  function automatic logic [WIDTH-1:0] getMark(logic [RW-1:0] r, int k);
    return r[(NP-k)*WIDTH +: WIDTH];
  endfunction

  function automatic logic [RW-1:0] randRuler();
    logic [RW-1:0] r;
    int m0, mN;
    m0 = int'($urandom_range(0, 3));
    mN = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 511)) : m0 + int'($urandom_range(12, 14));
    r = mkRuler(m0, int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), mN);
    return r;
  endfunction

  always @(posedge clock) begin : model
    logic [WIDTH-1:0] len;
    if (!reset || clear) begin
      mSlots.delete();
      mBest  = '1;
      mOvf   = 1'b0;
      mPhase = 0;
      mWord  = 0;
    end else begin
      case (mPhase)
        0: begin
          if (cand_valid) begin
            len = getMark(cand_marks, NP) - getMark(cand_marks, 0);
            if (len < mBest) begin
              mSlots.delete();
              mSlots.push_back(cand_marks);
              mBest = len;
              mOvf  = 1'b0;
            end else if (len == mBest) begin
              if (mSlots.size() < NR) mSlots.push_back(cand_marks);
              else mOvf = 1'b1;
            end
          end
          if (search_done) mPhase = 1;
        end
        1: begin
          if (rd_start && mSlots.size() > 0) begin
            mPhase = 2;
            mWord  = 0;
          end
        end
        default: begin
          if (rd_ready) begin
            if (mWord == mSlots.size() * NW - 1) mPhase = 1;
            else mWord++;
          end
        end
      endcase
    end
  end

  task automatic checkOutput(string name, logic [1023:0] actual, logic [1023:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    if (checkEn) begin : compare
      logic [NR*RW-1:0] expRes;
      logic [WIDTH-1:0] expData;
      expRes = '0;
      for (int i = 0; i < mSlots.size(); i++) expRes[(NR-1-i)*RW +: RW] = mSlots[i];
      expData = (mPhase == 2) ? getMark(mSlots[mWord / NW], mWord % NW) : '0;
      checkOutput("cand_ready", cand_ready, mPhase == 0);
      checkOutput("done", done, mPhase != 0);
      checkOutput("best_length", best_length, mBest);
      checkOutput("num_results", num_results, mSlots.size());
      checkOutput("overflow", overflow, mOvf);
      checkOutput("results", results, expRes);
      checkOutput("rd_valid", rd_valid, mPhase == 2);
      checkOutput("rd_data", rd_data, expData);
      checkOutput("rd_last", rd_last, (mPhase == 2) && (mWord == mSlots.size() * NW - 1));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(logic v, logic [RW-1:0] m, logic sd, logic rs, logic rr);
    cand_valid  = v;
    cand_marks  = m;
    search_done = sd;
    rd_start    = rs;
    rd_ready    = rr;
    tick();
    cand_valid  = 1'b0;
    cand_marks  = '0;
    search_done = 1'b0;
    rd_start    = 1'b0;
    rd_ready    = 1'b0;
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic offerSmall(logic [RW-1:0] m);
    sValid = 1'b1;
    sMarks = m;
    tick();
    sValid = 1'b0;
    sMarks = '0;
  endtask

  logic [RW-1:0] r0, r1;
  logic [WIDTH-1:0] held;
  int hs, cyc;
  bit stalled, toggle;

  initial begin
    reset = 1'b0; clear = 1'b0; cand_valid = 1'b0; cand_marks = '0;
    search_done = 1'b0; rd_start = 1'b0; rd_ready = 1'b0;
    sReset = 1'b0; sValid = 1'b0; sMarks = '0;

    repeat (3) tick();
    checkEn = 1'b1;
    checkOutput("reset_best", best_length, 511);
    checkOutput("reset_num", num_results, 0);
    checkOutput("reset_ready", cand_ready, 1);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_rdvalid", rd_valid, 0);
    reset = 1'b1;

    applyStimulus(1, mkRuler(0, 1, 4, 10, 12, 18), 0, 0, 0);
    applyStimulus(1, mkRuler(0, 1, 4, 10, 12, 17), 0, 0, 0);
    checkOutput("short_best", best_length, 17);
    checkOutput("short_num", num_results, 1);
    checkOutput("short_slot0", results[(NR-1)*RW +: RW], mkRuler(0, 1, 4, 10, 12, 17));
    checkOutput("short_slot1", results[(NR-2)*RW +: RW], 0);

    applyStimulus(1, mkRuler(0, 1, 4, 10, 15, 17), 0, 0, 0);
    applyStimulus(1, mkRuler(0, 1, 8, 11, 13, 17), 0, 0, 0);
    applyStimulus(1, mkRuler(0, 1, 2, 5, 9, 20), 0, 0, 0);
    checkOutput("eq_num", num_results, 3);
    checkOutput("eq_slot1", results[(NR-2)*RW +: RW], mkRuler(0, 1, 4, 10, 15, 17));
    checkOutput("eq_slot2", results[(NR-3)*RW +: RW], mkRuler(0, 1, 8, 11, 13, 17));

    applyStimulus(1, mkRuler(0, 1, 8, 12, 14, 17), 1, 0, 0);
    checkOutput("sim_num", num_results, 4);
    checkOutput("sim_slot3", results[(NR-4)*RW +: RW], mkRuler(0, 1, 8, 12, 14, 17));
    checkOutput("sim_done", done, 1);
    checkOutput("sim_ready", cand_ready, 0);

    pulseClear();
    r0 = mkRuler(0, 1, 4, 10, 12, 17);
    r1 = mkRuler(0, 1, 4, 10, 15, 17);
    applyStimulus(1, r0, 0, 0, 0);
    applyStimulus(1, r1, 1, 0, 0);
    applyStimulus(0, '0, 0, 1, 0);
    hs = 0; cyc = 0; stalled = 1'b0; toggle = 1'b1;
    while (hs < 12 && cyc < 60) begin
      if (stalled) checkOutput("rd_hold", rd_data, held);
      rd_ready = toggle;
      stalled  = 1'b0;
      if (rd_valid && rd_ready) begin
        checkOutput("rd_word", rd_data, getMark((hs < NW) ? r0 : r1, hs % NW));
        checkOutput("rd_lastflag", rd_last, hs == 11);
        hs++;
      end else if (rd_valid) begin
        held    = rd_data;
        stalled = 1'b1;
      end
      toggle = ~toggle;
      tick();
      cyc++;
    end
    rd_ready = 1'b0;
    checkOutput("rd_handshakes", hs, 12);
    checkOutput("rd_end_valid", rd_valid, 0);
    checkOutput("rd_end_done", done, 1);

    applyStimulus(0, '0, 0, 1, 0);
    repeat (3) applyStimulus(0, '0, 0, 0, 1);
    pulseClear();
    checkOutput("clr_rdvalid", rd_valid, 0);
    checkOutput("clr_ready", cand_ready, 1);
    checkOutput("clr_num", num_results, 0);

    sReset = 1'b1;
    offerSmall(mkRuler(0, 1, 4, 10, 12, 17));
    offerSmall(mkRuler(0, 1, 4, 10, 15, 17));
    offerSmall(mkRuler(0, 1, 8, 11, 13, 17));
    checkOutput("small_num", sNum, 2);
    checkOutput("small_ovf", sOvf, 1);
    offerSmall(mkRuler(0, 1, 3, 7, 12, 16));
    checkOutput("small_ovf_clr", sOvf, 0);
    checkOutput("small_num_1", sNum, 1);
    checkOutput("small_best", sBest, 16);

    for (int round = 0; round < 6; round++) begin
      pulseClear();
      for (int c = 0; c < 120; c++) begin
        applyStimulus($urandom_range(0, 9) < 7, randRuler(), $urandom_range(0, 99) == 0,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
      end
      applyStimulus(0, '0, 1, 0, 0);
      for (int c = 0; c < 150; c++) begin
        clear = ($urandom_range(0, 299) == 0);
        applyStimulus($urandom_range(0, 1) == 1, randRuler(), $urandom_range(0, 9) == 0,
                      $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 6);
        clear = 1'b0;
      end
    end

    @(posedge clock);
    #1;
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/golomb_result_store.md
Name: golomb_result_store

Overview:
- Result collector and host readout block for the Golomb ruler search engine.
- Sits between the mark-counter search core and the host interface.
- Accepts candidate rulers over a valid/ready handshake and keeps up to NUMRESULTS rulers that share the shortest length seen so far.
- After the search finishes, streams the stored rulers to the host one mark per beat.

Parameters:
- WIDTH, 9: bits per mark value.
- NUMPOSITIONS, 5: number of marks beyond mark 0; each ruler holds NUMPOSITIONS+1 marks.
- NUMRESULTS, 10: number of result slots.
- CNTW, 6: width of the result counter; must satisfy 2^CNTW > NUMRESULTS.

Ports:
- clock  in  1  single system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- clear  in  1  synchronous restart; empties storage and returns to COLLECT.
- cand_valid  in  1  candidate ruler present.
- cand_ready  out  1  block can accept a candidate.
- cand_marks  in  (NUMPOSITIONS+1)*WIDTH  packed {m0,...,mN}; m0 in the MSBs.
- search_done  in  1  single-cycle pulse from the search core: search exhausted.
- done  out  1  collection finished; results stable.
- best_length  out  WIDTH  shortest length accepted so far.
- num_results  out  CNTW  number of valid slots.
- overflow  out  1  an equal-length candidate was dropped because all slots were full.
- results  out  NUMRESULTS*(NUMPOSITIONS+1)*WIDTH  packed slots; slot 0 in the MSBs.
- rd_start  in  1  request a readout.
- rd_valid  out  1  rd_data is valid.
- rd_ready  in  1  host accepts rd_data.
- rd_data  out  WIDTH  current mark word.
- rd_last  out  1  final word of the final stored ruler.

Behaviour:
- Reset (reset==0 at posedge) gives:
  - state COLLECT, cand_ready=1, done=0, overflow=0, num_results=0;
  - best_length = all ones (2^WIDTH-1);
  - all slots zero;
  - rd_valid=0, rd_data=0, rd_last=0.
- clear==1 with reset==1 has the same effect as reset, from any state. It aborts a readout in progress.
- States are COLLECT, DONE and READ.
- In COLLECT:
  - cand_ready=1.
  - A candidate is accepted when cand_valid && cand_ready.
  - Length L = mN - m0, computed modulo 2^WIDTH.
  - If L < best_length: every slot is zeroed, slot 0 takes the candidate, num_results=1, best_length=L, overflow=0.
  - If L == best_length and num_results < NUMRESULTS: the candidate goes into slot num_results and num_results increments.
  - If L == best_length and num_results == NUMRESULTS: the candidate is discarded and overflow=1 (sticky until a shorter candidate, clear or reset).
  - If L > best_length: the candidate is discarded with no state change.
  - All updates are visible in the cycle after acceptance. Throughput is one candidate per cycle.
- search_done in COLLECT moves the state to DONE in the next cycle, and done=1 from that cycle on.
  - If search_done and an accepted candidate arrive in the same cycle, the candidate is processed first and is included.
- In DONE and READ: cand_ready=0 and done=1. search_done is ignored.
- rd_start in DONE with num_results>0 moves the state to READ in the next cycle. rd_start is ignored in COLLECT, in READ, and when num_results==0.
- READ:
  - Words are emitted in the order slot 0 m0..mN, then slot 1, and so on, up to slot num_results-1.
  - rd_valid is held high. rd_data and rd_last stay stable until the rd_valid && rd_ready handshake.
  - The next word appears in the cycle after a handshake, so back-to-back transfers run at one word per cycle.
  - rd_last=1 only on the final word.
  - After the handshake of the final word: rd_valid=0, the state returns to DONE, and a readout can be repeated.
- results slots with index >= num_results always read as zero.

Test Plan:
- Reset check (all params default): hold reset=0 for 3 cycles -> best_length=511, num_results=0, cand_ready=1, done=0, rd_valid=0.
- Shorter candidate replaces stored result: offer 0-1-4-10-12-18 then 0-1-4-10-12-17 -> best_length=17, num_results=1, slot 0 = 0-1-4-10-12-17, slot 1 zero.
- Equal- and longer-length candidates, back to back: offer 0-1-4-10-15-17, 0-1-8-11-13-17 and 0-1-2-5-9-20 -> num_results=3, the first two stored in slots 1 and 2, the length-20 ruler dropped.
- Overflow with the bench overriding NUMRESULTS=2: offer three distinct length-17 rulers -> num_results=2, overflow=1; then offer a length-16 ruler -> overflow=0, num_results=1.
- Simultaneous done and candidate: raise search_done in the same cycle as accepting 0-1-8-12-14-17 while best_length=17 -> it is stored; done=1 next cycle; cand_ready=0 afterwards.
- Readout with backpressure: rd_start with 2 stored rulers, rd_ready toggling 1,0,1,… -> exactly 12 handshakes; words in order; rd_data stable while rd_ready=0; rd_last only on the 12th word. Asserting clear mid-readout -> rd_valid=0 and state COLLECT next cycle.
